// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbitrated APB master.
// NUM_REQ requesters share one APB bus with four slaves. The bus is selected
// one-hot through Pselx, and each slave owns a 2**SLV_SIZE_LOG2 byte window
// starting at SLV_BASE. Addresses outside the four windows are answered
// locally through the ERR state, with no bus activity.
// Optional build macro: APB_PREADY_EN adds a Pready input so slaves can
// stretch the ACCESS phase with wait states.
module apb_master_arbiter #(
  parameter int          NUM_REQ       = 2,
  parameter logic [31:0] SLV_BASE      = 32'h8000_0000,
  parameter int          SLV_SIZE_LOG2 = 26,
  localparam int         IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clock,
  input  logic                  Hresetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic                  busy,
  output logic [31:0]           Paddr,
  output logic [31:0]           Pwdata,
  output logic [3:0]            Pselx,
  output logic                  Penable,
  output logic                  Pwrite,
  input  logic [31:0]           Prdata
`ifdef APB_PREADY_EN
  ,
  input  logic                  Pready
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;        // last requester granted
  logic [IDW-1:0] cur_id;     // requester owning the transfer in flight
  logic           cur_write;

  logic [IDW-1:0] winner;
  logic           found;
  logic           arb_en;
  logic           accept;
  logic           access_done;
  logic           sel_write;
  logic [31:0]    sel_addr;
  logic [31:0]    sel_wdata;
  logic [31:0]    offset;
  logic           hit;
  logic [1:0]     slv_k;

`ifdef APB_PREADY_EN
  assign access_done = Pready;
`else
  assign access_done = 1'b1;
`endif

  // Arbitration is allowed when idle and on the cycle an ACCESS closes.
  assign arb_en = (state == ST_IDLE) || ((state == ST_ACCESS) && access_done);
  assign accept = arb_en && found;
  assign busy   = (state != ST_IDLE);

  // Round-robin search: first the requesters above the pointer, then wrap to
  // the ones at or below it, so the last winner has the lowest priority.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip the assignment would infer a latch.
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) > ptr)) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) <= ptr)) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
  end

  // Grant is one-hot and combinational in the cycle the winner is consumed.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (winner == IDW'(i));
    end
  end

  // Multiplex the winning requester's fields and decode its address.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = 32'h0;
    sel_wdata = 32'h0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*32 +: 32];
        sel_wdata = req_wdata[i*32 +: 32];
      end
    end
    // Unsigned wrap sends addresses below the base far out of range.
    offset = sel_addr - SLV_BASE;
    hit    = {1'b0, offset} < (33'd4 << SLV_SIZE_LOG2);
    slv_k  = 2'(offset >> SLV_SIZE_LOG2);
  end

  // Phase sequencer; an accept overrides the default next-state of the
  // completing ACCESS so a new SETUP follows with no idle cycle.
  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      ptr       <= IDW'(NUM_REQ - 1);
      cur_id    <= '0;
      cur_write <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      Paddr     <= 32'h0;
      Pwdata    <= 32'h0;
      Pselx     <= 4'h0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values; the later accept branch can then override earlier defaults.
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
        end
        ST_SETUP: begin
          Penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (access_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_err   <= 1'b0;
            rsp_rdata <= cur_write ? 32'h0 : Prdata;
            Pselx     <= 4'h0;
            Penable   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_ERR: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
          rsp_err   <= 1'b1;
          rsp_rdata <= 32'h0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        ptr       <= winner;
        cur_id    <= winner;
        cur_write <= sel_write;
        Penable   <= 1'b0;
        if (hit) begin
          state  <= ST_SETUP;
          Pselx  <= 4'b0001 << slv_k;
          Paddr  <= sel_addr;
          Pwrite <= sel_write;
          Pwdata <= sel_write ? sel_wdata : 32'h0;
        end else begin
          state <= ST_ERR;
          Pselx <= 4'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter. A transaction-level model plans
// each accepted request as a timeline of expected bus and response values
// per cycle; randomized and directed requests are both checked against it.
module tb_apb_master_arbiter;

  localparam int          NUM_REQ  = 3;
  localparam int          IDW      = 2;
  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int          WIN_LOG2 = 26;

  logic                  clock = 1'b0;
  logic                  Hresetn = 1'b0;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_err;
  logic [31:0]           rsp_rdata;
  logic                  busy;
  logic [31:0]           Paddr;
  logic [31:0]           Pwdata;
  logic [3:0]            Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [31:0]           Prdata;
`ifdef APB_PREADY_EN
  logic                  pready;
`endif

  always #5 clock = ~clock;

  apb_master_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .SLV_BASE     (BASE),
    .SLV_SIZE_LOG2(WIN_LOG2)
  ) dut (
    .clock    (clock),
    .Hresetn  (Hresetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Pselx    (Pselx),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Prdata   (Prdata)
`ifdef APB_PREADY_EN
    ,
    .Pready   (pready)
`endif
  );

  typedef struct {
    bit          valid;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t pend [NUM_REQ];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, next_arb, last_win, refill_pct;
  logic [NUM_REQ-1:0] refill_mask;
  bit hits_only, fixed_prdata;
  logic [31:0] prdata_val;

  // Planned per-cycle expectations; absent entries mean idle bus / no rsp.
  logic [3:0]  e_psel   [int];
  bit          e_pen    [int];
  logic [31:0] e_paddr  [int];
  logic [31:0] e_pwdata [int];
  bit          e_pwrite [int];
  bit          e_busy   [int];
  int          e_rsp_id [int];
  bit          e_rsp_err[int];
  int          e_rsp_src[int];
  logic [31:0] prd_log  [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Slave index of an address by plain division, -1 when outside all windows.
  function automatic int slave_of(input logic [31:0] a);
    logic [31:0] off;
    logic [31:0] q;
    off = a - BASE;
    q   = off / (32'd1 << WIN_LOG2);
    if (q < 32'd4) return int'(q);
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr(input bit only_hits);
    logic [31:0] a;
    int sel;
    sel = only_hits ? 0 : int'($urandom_range(0, 5));
    case (sel)
      0, 1, 2: a = BASE + ($urandom_range(0, 3) << WIN_LOG2) + ($urandom & 32'h03FF_FFFC);
      3:       a = BASE + 32'h1000_0000 + ($urandom & 32'h03FF_FFFC);
      4:       a = BASE - 32'd4 - ($urandom_range(0, 1000) << 2);
      default: begin
        case ($urandom_range(0, 3))
          0:       a = BASE;
          1:       a = BASE + 32'h0FFF_FFFC;
          2:       a = BASE + 32'h1000_0000;
          default: a = BASE - 32'd4;
        endcase
      end
    endcase
    return a;
  endfunction

  task automatic set_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    pend[i].valid = 1'b1;
    pend[i].write = w;
    pend[i].addr  = a;
    pend[i].wdata = d;
  endtask

  task automatic model_reset();
    e_psel.delete();  e_pen.delete();    e_paddr.delete();  e_pwdata.delete();
    e_pwrite.delete(); e_busy.delete();  e_rsp_id.delete(); e_rsp_err.delete();
    e_rsp_src.delete(); prd_log.delete();
    for (int i = 0; i < NUM_REQ; i++) pend[i].valid = 1'b0;
    last_win = NUM_REQ - 1;
    next_arb = cyc;
  endtask

  // Plan the whole life of a request accepted in cycle c.
  task automatic schedule(input int c, input int w);
    int s;
    s = slave_of(pend[w].addr);
    if (s >= 0) begin
      for (int d = 1; d <= 2; d++) begin
        e_psel[c+d]   = 4'(1 << s);
        e_pen[c+d]    = (d == 2);
        e_paddr[c+d]  = pend[w].addr;
        e_pwrite[c+d] = pend[w].write;
        e_pwdata[c+d] = pend[w].write ? pend[w].wdata : 32'h0;
        e_busy[c+d]   = 1'b1;
      end
      e_rsp_id[c+3]  = w;
      e_rsp_err[c+3] = 1'b0;
      e_rsp_src[c+3] = pend[w].write ? -1 : c + 2;
    end else begin
      e_busy[c+1]    = 1'b1;
      e_rsp_id[c+2]  = w;
      e_rsp_err[c+2] = 1'b1;
      e_rsp_src[c+2] = -1;
    end
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge.
  task automatic step();
    logic [NUM_REQ-1:0] exp_ready;
    int win;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]          = pend[i].valid;
      req_write[i]          = pend[i].valid ? pend[i].write : 1'b0;
      req_addr[i*32 +: 32]  = pend[i].valid ? pend[i].addr  : 32'h0;
      req_wdata[i*32 +: 32] = pend[i].valid ? pend[i].wdata : 32'h0;
    end
    Prdata       = fixed_prdata ? prdata_val : $urandom;
    prd_log[cyc] = Prdata;
    @(negedge clock);
    exp_ready = '0;
    win       = -1;
    if (cyc >= next_arb) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (last_win + k) % NUM_REQ;
        if (win < 0 && pend[idx].valid) win = idx;
      end
      if (win >= 0) begin
        exp_ready = NUM_REQ'(1) << win;
        schedule(cyc, win);
        last_win = win;
        next_arb = cyc + 2;
      end else begin
        next_arb = cyc + 1;
      end
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("pselx",     32'(Pselx),   e_psel.exists(cyc) ? 32'(e_psel[cyc]) : 32'h0);
    check("penable",   32'(Penable), e_pen.exists(cyc)  ? 32'(e_pen[cyc])  : 32'h0);
    check("busy",      32'(busy),    e_busy.exists(cyc) ? 32'h1 : 32'h0);
    check("rsp_valid", 32'(rsp_valid), e_rsp_id.exists(cyc) ? 32'h1 : 32'h0);
    if (e_psel.exists(cyc)) begin
      check("paddr",  Paddr,          e_paddr[cyc]);
      check("pwrite", 32'(Pwrite),    32'(e_pwrite[cyc]));
      check("pwdata", Pwdata,         e_pwdata[cyc]);
    end
    if (e_rsp_id.exists(cyc)) begin
      check("rsp_id",    32'(rsp_id),  32'(e_rsp_id[cyc]));
      check("rsp_err",   32'(rsp_err), 32'(e_rsp_err[cyc]));
      check("rsp_rdata", rsp_rdata, (e_rsp_src[cyc] >= 0) ? prd_log[e_rsp_src[cyc]] : 32'h0);
    end
    @(posedge clock);
    #1;
    if (win >= 0) pend[win].valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pend[i].valid && refill_mask[i] && (int'($urandom_range(0, 99)) < refill_pct))
        set_req(i, 1'($urandom_range(0, 1)), rand_addr(hits_only), $urandom);
    end
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; Prdata = 32'h0;
`ifdef APB_PREADY_EN
    pready = 1'b1;
`endif
    refill_mask = '0; refill_pct = 0; hits_only = 1'b0;
    fixed_prdata = 1'b0; prdata_val = 32'h0; cyc = 0;
    model_reset();

    // Reset state.
    #12;
    check("rst_pselx",     32'(Pselx),     32'h0);
    check("rst_penable",   32'(Penable),   32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_paddr",     Paddr,          32'h0);
    check("rst_rsp_rdata", rsp_rdata,      32'h0);
    @(negedge clock);
    Hresetn = 1'b1;
    @(posedge clock);
    #1;
    model_reset();

    // Single read to slave 0 returning DEAD_BEEF.
    fixed_prdata = 1'b1; prdata_val = 32'hDEAD_BEEF;
    set_req(0, 1'b0, 32'h8000_0010, 32'h0);
    steps(5);
    fixed_prdata = 1'b0;

    // Single write to slave 3.
    set_req(1, 1'b1, 32'h8C00_0004, 32'h1234_5678);
    steps(5);

    // Two requesters continuously valid: alternating grants, no idle gap.
    hits_only = 1'b1; refill_mask = 3'b011; refill_pct = 100;
    set_req(0, 1'b0, rand_addr(1'b1), 32'h0);
    set_req(1, 1'b1, rand_addr(1'b1), $urandom);
    steps(9);
    refill_pct = 0; hits_only = 1'b0;
    steps(8);

    // Decode misses: just above the last window, and just below the base.
    set_req(0, 1'b0, 32'h9000_0000, 32'h0);
    steps(4);
    set_req(0, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF);
    steps(4);

    // Randomized traffic on all requesters, hits, misses and window edges.
    refill_mask = '1; refill_pct = 50;
    steps(300);
    refill_pct = 0;
    steps(12);

    // Asynchronous reset in the middle of an ACCESS phase.
    set_req(0, 1'b0, 32'h8400_0100, 32'h0);
    steps(2);
    check("pre_rst_penable", 32'(Penable), 32'h1);
    Hresetn = 1'b0;
    #1;
    check("arst_pselx",     32'(Pselx),     32'h0);
    check("arst_penable",   32'(Penable),   32'h0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("arst_busy",      32'(busy),      32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    Hresetn = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    set_req(1, 1'b0, 32'h8800_0040, 32'h0);
    set_req(0, 1'b1, 32'h8000_0080, 32'hA5A5_5A5A);
    steps(10);

`ifdef APB_PREADY_EN
    // Wait states: Pready low for three ACCESS cycles.
    Hresetn = 1'b0;
    @(negedge clock);
    Hresetn = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 3'b001; req_write = '0; req_addr = '0; req_addr[31:0] = 32'h8400_0020;
    @(negedge clock);
    check("prdy_ready", 32'(req_ready), 32'h1);
    @(posedge clock);
    #1;
    req_valid = '0;
    @(negedge clock);
    check("prdy_setup_psel", 32'(Pselx),   32'h2);
    check("prdy_setup_pen",  32'(Penable), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      pready = 1'b0;
      @(negedge clock);
      check("prdy_wait_pen",  32'(Penable),   32'h1);
      check("prdy_wait_psel", 32'(Pselx),     32'h2);
      check("prdy_wait_rsp",  32'(rsp_valid), 32'h0);
      check("prdy_wait_addr", Paddr,          32'h8400_0020);
    end
    @(posedge clock);
    #1;
    pready = 1'b1; Prdata = 32'hCAFE_F00D;
    @(negedge clock);
    check("prdy_last_pen", 32'(Penable),   32'h1);
    check("prdy_last_rsp", 32'(rsp_valid), 32'h0);
    @(posedge clock);
    #1;
    Prdata = 32'h0;
    @(negedge clock);
    check("prdy_rsp_valid", 32'(rsp_valid), 32'h1);
    check("prdy_rsp_rdata", rsp_rdata,      32'hCAFE_F00D);
    check("prdy_done_psel", 32'(Pselx),     32'h0);
    @(negedge clock);
    check("prdy_rsp_pulse", 32'(rsp_valid), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Round-robin arbitrated APB master. Shares one APB bus (4 slaves, one-hot Pselx) between NUM_REQ requesters.
- Sequences the SETUP/ACCESS phases, decodes the address to a slave select, and returns read data and error status to the winning requester.
- Sits on the bridge side, driving the signals that the APB interface's driver/monitor clocking blocks sample.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- SLV_BASE, 32'h8000_0000, base address of slave 0.
- SLV_SIZE_LOG2, 26, log2 of each slave's window; slave k = [SLV_BASE + k<<SLV_SIZE_LOG2, +window).

Ports:
- clock  in  1  single clock, all logic on posedge
- Hresetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request pending, per requester
- req_ready  out  NUM_REQ  one-hot; request consumed on this clock edge
- req_write  in  NUM_REQ  1 = write
- req_addr  in  NUM_REQ*32  flattened, requester i at [32i+31:32i]
- req_wdata  in  NUM_REQ*32  flattened write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  max(1,$clog2(NUM_REQ))  index of the completed requester
- rsp_err  out  1  address decode miss
- rsp_rdata  out  32  captured Prdata; 0 for writes and errors
- busy  out  1  state != IDLE
- Paddr  out  32  APB address
- Pwdata  out  32  APB write data; 0 on reads
- Pselx  out  4  one-hot slave select
- Penable  out  1  ACCESS phase
- Pwrite  out  1  APB direction
- Prdata  in  32  APB read data

Behaviour:
- Reset (Hresetn=0, asynchronous): state=IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 wins first. Reset mid-transfer drops Pselx/Penable immediately and issues no rsp.
- States: IDLE, SETUP, ACCESS, ERR. All APB outputs and rsp_* are registered.
- Arbitration:
  - Occurs in IDLE, and in ACCESS on its completing cycle.
  - Winner = first asserted req_valid searching from pointer+1, wrapping mod NUM_REQ.
  - req_ready[winner] is combinational in that cycle. On the edge, the request fields are latched and the pointer is set to the winner.
  - Requesters present the next request or drop req_valid after the ready edge. A valid request must be held stable until ready.
- Decode: slave k hit iff req_addr - SLV_BASE < 4<<SLV_SIZE_LOG2, with k = offset>>SLV_SIZE_LOG2. Unsigned subtraction, so addresses below base miss.
- Accept with hit:
  - Next state SETUP: Pselx=1<<k, Penable=0, Paddr/Pwrite latched, Pwdata = wdata if write else 0.
- SETUP -> ACCESS unconditionally; Penable=1, all other APB signals held.
- ACCESS (completing cycle):
  - On the closing edge: Prdata is captured if a read; rsp_valid=1, rsp_id, rsp_err=0.
  - If another request is pending, it is accepted in the same cycle and the next state is SETUP. Penable=0 and Pselx is re-driven to the new slave. No idle cycle is inserted, and SETUP always precedes ACCESS.
  - Otherwise the next state is IDLE: Pselx=0, Penable=0, Paddr/Pwrite/Pwdata hold their last values.
- Accept with miss:
  - Next state ERR: no APB activity.
  - ERR lasts one cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - ERR -> IDLE; arbitration does not occur in ERR.
- Latency (hit, no wait): request accepted at edge E0; SETUP E0..E1; ACCESS E1..E2; rsp_valid high in the cycle after E2. Back-to-back throughput is 1 transfer per 2 cycles.
- Simultaneous requests: strictly round-robin; a requester is never served twice while another is waiting.
- Pselx is always one-hot or zero. Penable=1 only in ACCESS with Pselx!=0.

Optional Feature:
- Macro: APB_PREADY_EN.
- Defined:
  - Adds input port Pready (1 bit) after Prdata.
  - ACCESS completes only on an edge where Pready=1; while Pready=0, all APB outputs are held, no rsp is issued and no arbitration occurs.
  - Prdata is captured on the Pready=1 edge.
- Undefined: no Pready port; ACCESS is always exactly one cycle.

Test Plan:
- Reset, then req0 read 0x8000_0010 with Prdata=32'hDEAD_BEEF -> Pselx=4'b0001 SETUP 1 cycle, Penable ACCESS 1 cycle; rsp_valid, rsp_id=0, rsp_rdata=DEAD_BEEF, rsp_err=0.
- req1 write 0x8C00_0004 data 32'h1234_5678 -> Pselx=4'b1000, Pwrite=1, Pwdata=1234_5678, rsp_rdata=0.
- req0 and req1 both valid continuously, 4 transfers -> grant order 0,1,0,1; Penable pattern 0,1,0,1 with no idle gap; Pselx never 0 between transfers.
- req0 addr 0x9000_0000, then 0x7FFF_FFFC -> no Pselx activity; each gives rsp_err=1, rsp_rdata=0, 2 cycles after acceptance.
- Hresetn asserted during ACCESS -> Pselx, Penable, rsp_valid and busy go 0 without waiting for a clock edge; after release, req0 is served first.
- APB_PREADY_EN defined, Pready low for 3 cycles -> ACCESS lasts 4 cycles, outputs held, single rsp_valid pulse.
